// File: rtl/rr_arbiter8.sv
// ---------------------------------------------------------------------------
// rr_arbiter8
//
// Eight-way round-robin arbiter with a bounded grant tenure. A rotating
// priority pointer decides who wins when several requesters are active, so no
// requester has fixed precedence. A grant is held until the owner signals done,
// drops its request, or has held the resource for MAX_HOLD cycles. In the last
// case the grant is revoked and a one-cycle timeout pulse follows. Every grant
// is followed by exactly one idle cycle before the next grant can be issued.
//
// Parameters
//   MAX_HOLD    : maximum grant tenure in cycles (1..255)
//
// Ports
//   clk         : in  rising-edge clock for all state
//   rst         : in  synchronous, active-high reset
//   req[7:0]    : in  level request per requester, held until served
//   done        : in  owner releases the resource (only looked at while granted)
//   grant[7:0]  : out registered one-hot grant, or all-zero
//   grant_idx   : out registered binary index of the granted requester
//   grant_valid : out high while a grant is held
//   timeout     : out one-cycle pulse after a grant is revoked by the tenure limit
// ---------------------------------------------------------------------------
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_idx,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ptr_q, ptr_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  grant_q, grant_d;
  logic [2:0]  idx_q, idx_d;
  logic        timeout_q, timeout_d;

  logic [15:0] reqDoubled;
  logic [15:0] reqShifted;
  logic [7:0]  reqRotated;
  logic [2:0]  pickOffset;
  logic        pickFound;
  logic [2:0]  pickIdx;
  logic        ownerReq;
  logic        holdLimit;
  logic        release_w;

  // Rotate the request vector so that bit 0 corresponds to the pointer
  // position. Concatenating req with itself makes the rotation a plain shift,
  // and the wrap from index 7 back to 0 falls out naturally.
  always_comb begin
    reqDoubled = {req, req};
    reqShifted = reqDoubled >> ptr_q;
    reqRotated = reqShifted[7:0];
  end

  // Find the lowest set bit of the rotated vector, i.e. the first active
  // requester at or after the pointer. The loop runs from high to low so the
  // smallest offset is the last one written and therefore wins.
  always_comb begin
    pickOffset = 3'd0;
    pickFound  = 1'b0;
    for (int off = 7; off >= 0; off--) begin
      if (reqRotated[off]) begin
        pickOffset = 3'(off);
        pickFound  = 1'b1;
      end
    end
    pickIdx = ptr_q + pickOffset;
  end

  // Release conditions for the current owner. The hold counter starts at zero
  // on the grant edge, so reaching MAX_HOLD-1 means the owner has already had
  // MAX_HOLD cycles of tenure.
  always_comb begin
    ownerReq  = req[idx_q];
    holdLimit = (hold_q == 8'(MAX_HOLD - 1));
    release_w = done || !ownerReq || holdLimit;
  end

  // Next-state logic. While a grant is held the grant vector and index stay
  // frozen regardless of other requests. On release the pointer moves just
  // past the old owner so everyone else gets a turn before it is served again.
  // The timeout pulse is only raised when the hold limit is the sole reason
  // for the release.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = 8'd0;
        if (pickFound) begin
          state_d = GRANT;
          grant_d = 8'd1 << pickIdx;
          idx_d   = pickIdx;
        end else begin
          grant_d = 8'd0;
          idx_d   = 3'd0;
        end
      end
      GRANT: begin
        if (release_w) begin
          state_d   = IDLE;
          grant_d   = 8'd0;
          idx_d     = 3'd0;
          hold_d    = 8'd0;
          ptr_d     = idx_q + 3'd1;
          timeout_d = !done && ownerReq;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'd0;
        idx_d   = 3'd0;
        hold_d  = 8'd0;
      end
    endcase
  end

  // State registers. Reset wins over everything, including an active grant,
  // and never produces a timeout pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      hold_q    <= 8'd0;
      grant_q   <= 8'd0;
      idx_q     <= 3'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_q   <= grant_d;
      idx_q     <= idx_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = (state_q == GRANT);
  assign timeout     = timeout_q;

endmodule
